// File: rtl/q_bias_requant.sv
// q_bias_requant: Q-projection output stage.
// Adds ROM bias per lane, rounds, shifts and saturates to packed int8.
module q_bias_requant #(
    parameter int N_COL = 128,
    parameter int ROWS  = 32,
    parameter int SHIFT = 8,
    localparam int AW = $clog2(N_COL),
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          acc_valid,
    output logic          acc_ready,
    input  logic [127:0]  acc_data,
    output logic [AW-1:0] a1,
    output logic [AW-1:0] a2,
    output logic [AW-1:0] a3,
    output logic [AW-1:0] a4,
    input  logic [127:0]  bias,
    output logic          q_valid,
    input  logic          q_ready,
    output logic [31:0]   q_data,
    output logic          q_last,
    output logic          q_pass_end
);

    localparam logic [AW-1:0] COL_LAST = AW'(N_COL - 4);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic signed [33:0] RND    = 34'sd1 <<< (SHIFT - 1);
    localparam logic signed [33:0] SAT_HI = 34'sd127;
    localparam logic signed [33:0] SAT_LO = -34'sd128;

    typedef struct packed {
        logic            valid;
        logic            last;
        logic            pend;
        logic [3:0][32:0] sum;
    } s1_t;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic        pend;
        logic [31:0] data;
    } s2_t;

    logic [AW-1:0] r_col;
    logic [RW-1:0] r_row;
    s1_t           r_s1;
    s2_t           r_s2;

    logic             w_en;
    logic             w_accept;
    logic             w_col_last;
    logic             w_row_last;
    logic [3:0][32:0] w_sum;
    logic [31:0]      w_q;

    // Round half toward +inf, arithmetic shift, clamp to int8.
    function automatic logic [7:0] f_requant(input logic [32:0] s);
        logic signed [33:0] t;
        t = ($signed({s[32], s}) + RND) >>> SHIFT;
        if (t > SAT_HI) begin
            f_requant = 8'h7F;
        end else if (t < SAT_LO) begin
            f_requant = 8'h80;
        end else begin
            f_requant = t[7:0];
        end
    endfunction

    assign w_en       = !r_s2.valid || q_ready;
    assign acc_ready  = w_en && !rst && !clr;
    assign w_accept   = acc_valid && acc_ready;
    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);

    assign a1 = r_col;
    assign a2 = r_col + AW'(1);
    assign a3 = r_col + AW'(2);
    assign a4 = r_col + AW'(3);

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < 4; k++) begin
            w_sum[k] = {acc_data[32*k+31], acc_data[32*k +: 32]}
                     + {bias[32*k+31], bias[32*k +: 32]};
        end
    end

    always_comb begin
        w_q = '0;
        for (int k = 0; k < 4; k++) begin
            w_q[8*k +: 8] = f_requant(r_s1.sum[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + AW'(4);
            end
        end
    end

    // Both stages advance together; a stall freezes the whole pipe.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else if (w_en) begin
            r_s1.valid <= w_accept;
            r_s1.last  <= w_accept && w_col_last;
            r_s1.pend  <= w_accept && w_col_last && w_row_last;
            if (w_accept) begin
                r_s1.sum <= w_sum;
            end
            r_s2.valid <= r_s1.valid;
            r_s2.last  <= r_s1.valid && r_s1.last;
            r_s2.pend  <= r_s1.valid && r_s1.pend;
            if (r_s1.valid) begin
                r_s2.data <= w_q;
            end
        end
    end

    assign q_valid    = r_s2.valid;
    assign q_data     = r_s2.data;
    assign q_last     = r_s2.valid && r_s2.last;
    assign q_pass_end = r_s2.valid && r_s2.pend;

endmodule
